// File: rtl/int_alu_arbiter.sv
// int_alu_arbiter: round-robin shared 32-bit add/sub datapath with registered valid/ready result
//   clk, rst_n (async, active-low)
//   req/op_sub/sext_a [NREQ]  per-requester request, op (1=A-B), sign-extend A
//   a_flat [NREQ*AW], b_flat [NREQ*W]  operands, requester i at slice i
//   gnt [NREQ]  one-hot grant, operands captured at this edge
//   res_valid/res_ready/res_id/result/res_ovf  registered result hand-off
//   INT_ARB_STATS_EN adds op_count (saturating accepted-result count) and ovf_seen (sticky)
module int_alu_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int AW   = 16,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   op_sub,
  input  logic [NREQ-1:0]   sext_a,
  input  logic [NREQ*AW-1:0] a_flat,
  input  logic [NREQ*W-1:0] b_flat,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [W-1:0]      result,
  output logic              res_ovf
`ifdef INT_ARB_STATS_EN
  ,
  output logic [15:0]       op_count,
  output logic              ovf_seen
`endif
);
  typedef enum logic {IDLE, RESULT} state_t;
  state_t r_state, w_next;
  logic [IDW-1:0] r_ptr, w_win, w_ptr_nxt;
  logic [IDW:0] w_idx;
  logic [2*NREQ-1:0] w_rot;
  logic w_found, w_fire, w_sub, w_sext, w_ovf;
  logic [AW-1:0] w_a;
  logic [W-1:0] w_b, w_aext, w_sum;
  // rotate requests so bit 0 is the requester at ptr; first set bit wins
  always_comb begin
    w_rot = {req, req} >> r_ptr;
    w_found = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      w_idx = (w_idx >= (IDW+1)'(NREQ)) ? w_idx - (IDW+1)'(NREQ) : w_idx;
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_win = w_idx[IDW-1:0];
      end
    end
  end
  always_comb begin
    w_a = '0;
    w_b = '0;
    w_sub = 1'b0;
    w_sext = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (IDW'(k) == w_win) begin
        w_a = a_flat[k*AW +: AW];
        w_b = b_flat[k*W +: W];
        w_sub = op_sub[k];
        w_sext = sext_a[k];
      end
    end
  end
  assign w_aext = w_sext ? {{(W-AW){w_a[AW-1]}}, w_a} : {{(W-AW){1'b0}}, w_a};
  assign w_sum = w_sub ? w_aext - w_b : w_aext + w_b;
  assign w_ovf = (w_sub ? (w_aext[W-1] != w_b[W-1]) : (w_aext[W-1] == w_b[W-1])) & (w_sum[W-1] != w_aext[W-1]);
  assign w_ptr_nxt = (w_win == IDW'(NREQ-1)) ? '0 : w_win + IDW'(1);
  assign res_valid = (r_state == RESULT);
  // a grant is only possible when the output register is free or being drained this edge
  always_comb begin
    w_fire = w_found & ((r_state == IDLE) | res_ready);
    gnt = w_fire ? ({{(NREQ-1){1'b0}}, 1'b1} << w_win) : '0;
    w_next = w_fire ? RESULT : ((r_state == RESULT) && !res_ready) ? RESULT : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      result <= '0;
      res_id <= '0;
      res_ovf <= 1'b0;
    end else if (w_fire) begin
      r_ptr <= w_ptr_nxt;
      result <= w_sum;
      res_id <= w_win;
      res_ovf <= w_ovf;
    end
  end
`ifdef INT_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
      ovf_seen <= 1'b0;
    end else if (res_valid && res_ready) begin
      op_count <= (op_count != 16'hFFFF) ? op_count + 16'd1 : op_count;
      ovf_seen <= ovf_seen | res_ovf;
    end
  end
`endif
endmodule

// File: tb/tb_int_alu_arbiter.sv
// tb_int_alu_arbiter: directed scoreboard bench for int_alu_arbiter
module tb_int_alu_arbiter;
  typedef struct packed {logic [1:0] id; logic [31:0] res; logic ovf;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0, op_sub = '0, sext_a = '0, gnt;
  logic [63:0] a_flat = '0;
  logic [127:0] b_flat = '0;
  logic res_valid, res_ready = 1'b1, res_ovf;
  logic [1:0] res_id;
  logic [31:0] result;
`ifdef INT_ARB_STATS_EN
  logic [15:0] op_count;
  logic ovf_seen;
`endif
  exp_t q[$];
  exp_t e;
  logic [31:0] exp_res[4];
  logic exp_ovf[4];
  int checks = 0, errors = 0;
  int_alu_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_sub(op_sub), .sext_a(sext_a),
    .a_flat(a_flat), .b_flat(b_flat), .gnt(gnt), .res_valid(res_valid),
    .res_ready(res_ready), .res_id(res_id), .result(result), .res_ovf(res_ovf)
`ifdef INT_ARB_STATS_EN
    , .op_count(op_count), .ovf_seen(ovf_seen)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got id=%0d res=%h ovf=%b, none expected", res_id, result, res_ovf);
      end else begin
        e = q.pop_front();
        if ({res_id, result, res_ovf} !== {e.id, e.res, e.ovf}) begin
          errors++;
          $display("FAIL result: got id=%0d res=%h ovf=%b, want id=%0d res=%h ovf=%b", res_id, result, res_ovf, e.id, e.res, e.ovf);
        end
      end
    end
  end
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask
  task automatic setop(input int i, input logic [15:0] a, input logic [31:0] b, input logic s, input logic x, input logic [31:0] er, input logic eo);
    a_flat[i*16 +: 16] = a;
    b_flat[i*32 +: 32] = b;
    op_sub[i] = s;
    sext_a[i] = x;
    exp_res[i] = er;
    exp_ovf[i] = eo;
  endtask
  task automatic go(input logic [3:0] r, input logic rdy);
    @(posedge clk);
    #1;
    req = r;
    res_ready = rdy;
  endtask
  task automatic chk(input logic [3:0] eg);
    @(negedge clk);
    check("gnt", 64'(gnt), 64'(eg));
    for (int k = 0; k < 4; k++)
      if (eg[k]) q.push_back('{id: 2'(k), res: exp_res[k], ovf: exp_ovf[k]});
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    req = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_id", 64'(res_id), 64'd0);
    check("rst_ovf", 64'(res_ovf), 64'd0);
    check("rst_gnt", 64'(gnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // zero extension, then back-to-back on the same requester
    go(4'b0001, 1'b1); setop(0, 16'h1234, 32'h0, 1'b0, 1'b0, 32'h00001234, 1'b0); chk(4'b0001);
    go(4'b0001, 1'b1); setop(0, 16'h8000, 32'h0, 1'b0, 1'b0, 32'h00008000, 1'b0); chk(4'b0001);
    go(4'b0000, 1'b1); chk(4'b0000);
    // pass-through, sign extension wrap, subtract
    go(4'b0010, 1'b1); setop(1, 16'h0000, 32'h12345678, 1'b0, 1'b0, 32'h12345678, 1'b0); chk(4'b0010);
    go(4'b0010, 1'b1); setop(1, 16'hFFFF, 32'h1, 1'b0, 1'b1, 32'h00000000, 1'b0); chk(4'b0010);
    go(4'b0010, 1'b1); setop(1, 16'h0000, 32'h1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0); chk(4'b0010);
    go(4'b0000, 1'b1); chk(4'b0000);
    // round robin from a fresh pointer
    do_reset();
    for (int k = 0; k < 4; k++) setop(k, 16'(k), 32'h100, 1'b0, 1'b0, 32'h100 + 32'(k), 1'b0);
    go(4'b1111, 1'b1); chk(4'b0001);
    go(4'b1111, 1'b1); chk(4'b0010);
    go(4'b1111, 1'b1); chk(4'b0100);
    go(4'b1111, 1'b1); chk(4'b1000);
    go(4'b1111, 1'b1); chk(4'b0001);
    // backpressure: requester 0's result must sit still
    for (int s = 0; s < 3; s++) begin
      go(4'b1111, 1'b0);
      chk(4'b0000);
      check("stall_hold", {31'd0, res_valid, res_ovf, res_id, result}, {31'd0, 1'b1, 1'b0, 2'd0, 32'h100});
    end
    go(4'b1111, 1'b1); chk(4'b0010);
    go(4'b0000, 1'b1); chk(4'b0000);
    // signed overflow cases
    go(4'b0100, 1'b1); setop(2, 16'h0001, 32'h7FFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b1); chk(4'b0100);
    go(4'b1000, 1'b1); setop(3, 16'h8000, 32'h7FFFFFFF, 1'b1, 1'b1, 32'h7FFF8001, 1'b1); chk(4'b1000);
    go(4'b0000, 1'b1); chk(4'b0000);
    @(negedge clk);
`ifdef INT_ARB_STATS_EN
    check("op_count_8", 64'(op_count), 64'd8);
    check("ovf_seen_1", 64'(ovf_seen), 64'd1);
`endif
    // asynchronous reset while a result is pending
    for (int k = 0; k < 4; k++) setop(k, 16'(k), 32'h100, 1'b0, 1'b0, 32'h100 + 32'(k), 1'b0);
    go(4'b0001, 1'b1); setop(0, 16'h0005, 32'h5, 1'b0, 1'b0, 32'h0000000A, 1'b0); chk(4'b0001);
    @(posedge clk);
    #1;
    req = '0;
    check("pre_rst_valid", 64'(res_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_valid", 64'(res_valid), 64'd0);
    check("async_result", 64'(result), 64'd0);
    if (q.size() > 0) void'(q.pop_front());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`ifdef INT_ARB_STATS_EN
    check("op_count_rst", 64'(op_count), 64'd0);
    check("ovf_seen_rst", 64'(ovf_seen), 64'd0);
`endif
    setop(0, 16'h0000, 32'h100, 1'b0, 1'b0, 32'h100, 1'b0);
    go(4'b1111, 1'b1); chk(4'b0001);
    go(4'b1111, 1'b1); chk(4'b0010);
    go(4'b1111, 1'b1); chk(4'b0100);
    go(4'b0000, 1'b1); chk(4'b0000);
    @(negedge clk);
`ifdef INT_ARB_STATS_EN
    check("op_count_3", 64'(op_count), 64'd3);
    check("ovf_seen_0", 64'(ovf_seen), 64'd0);
`endif
    check("final_valid", 64'(res_valid), 64'd0);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
